// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit CPU
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] mem_rdata_op,
    input  logic       zero_flag,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_addr_sel,
    output logic       ir_load,
    output logic       imm_load,
    output logic       op1_load,
    output logic       op2_load,
    output logic [2:0] alu_op,
    output logic       reg_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        IMM    = 3'd3,
        EXEC   = 3'd4,
        MEM    = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_JZ  = 4'b1011;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state;
    logic [3:0]      opcode;
    logic [TO_W-1:0] to_cnt;
    logic            ack_ok;

    // An ack in the same cycle that en drops is discarded along with the request.
    assign ack_ok = mem_ack && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            opcode  <= 4'b0000;
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else if (state != HALT && !en) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE:   state <= FETCH;
                FETCH, IMM, MEM: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        to_cnt <= '0;
                        case (state)
                            FETCH: begin
                                opcode <= mem_rdata_op;
                                state  <= DECODE;
                            end
                            IMM:     state <= WB;
                            default: state <= (opcode == OP_ST) ? FETCH : WB;
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        bus_err <= 1'b1;
                        state   <= HALT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_MVI:       state <= IMM;
                        OP_LD, OP_ST: state <= MEM;
                        OP_HLT:       state <= HALT;
                        default:      state <= EXEC;
                    endcase
                end
                EXEC:    state <= opcode[3] ? FETCH : WB;
                WB:      state <= FETCH;
                default: state <= HALT;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 2'b00;
        ir_load      = 1'b0;
        imm_load     = 1'b0;
        op1_load     = 1'b0;
        op2_load     = 1'b0;
        alu_op       = 3'b000;
        reg_load     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                ir_load = ack_ok;
                pc_inc  = ack_ok;
            end
            IMM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 2'b01;
                imm_load     = ack_ok;
                pc_inc       = ack_ok;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 2'b10;
                mem_we       = (opcode == OP_ST);
            end
            DECODE: begin
                op1_load = 1'b1;
                op2_load = 1'b1;
            end
            EXEC: begin
                if (!opcode[3])
                    alu_op = opcode[2:0];
                else if (opcode == OP_JMP)
                    pc_load = 1'b1;
                else if (opcode == OP_JZ)
                    pc_load = zero_flag;
                else
                    illegal = 1'b1;
            end
            WB:      reg_load = 1'b1;
            HALT:    halted   = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with hand-computed cycle vectors
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] mem_rdata_op = 4'h0;
    logic       zero_flag = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, ir_load, imm_load, op1_load, op2_load;
    logic       reg_load, pc_inc, pc_load, halted, bus_err, illegal;
    logic [1:0] mem_addr_sel;
    logic [2:0] alu_op, state_dbg;

    cpu_sequencer #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mem_rdata_op(mem_rdata_op),
        .zero_flag(zero_flag), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
        .imm_load(imm_load), .op1_load(op1_load), .op2_load(op2_load),
        .alu_op(alu_op), .reg_load(reg_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .halted(halted), .bus_err(bus_err),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [19:0] REQ  = 20'h1 << 19;
    localparam logic [19:0] WE   = 20'h1 << 18;
    localparam logic [19:0] SEL1 = 20'h1 << 16;
    localparam logic [19:0] SEL2 = 20'h2 << 16;
    localparam logic [19:0] IR   = 20'h1 << 15;
    localparam logic [19:0] IMV  = 20'h1 << 14;
    localparam logic [19:0] OPS  = 20'h3 << 12;
    localparam logic [19:0] RL   = 20'h1 << 8;
    localparam logic [19:0] PCI  = 20'h1 << 7;
    localparam logic [19:0] PCL  = 20'h1 << 6;
    localparam logic [19:0] HLT  = 20'h1 << 5;
    localparam logic [19:0] BERR = 20'h1 << 4;
    localparam logic [19:0] ILL  = 20'h1 << 3;

    function automatic logic [19:0] alu(input logic [2:0] a);
        return {8'h0, a, 9'h0};
    endfunction

    typedef struct {
        logic [19:0] v;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   vec_id = 0;

    task automatic cyc(input logic r, input logic e, input logic [3:0] op,
                       input logic zf, input logic ack, input logic [19:0] exp);
        exp_t x;
        @(negedge clk);
        rst_n        = r;
        en           = e;
        mem_rdata_op = op;
        zero_flag    = zf;
        mem_ack      = ack;
        x.v  = exp;
        x.id = vec_id;
        vec_id++;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        logic [19:0] got;
        exp_t        x;
        #3;
        if (sb.size() > 0) begin
            x   = sb.pop_front();
            got = {mem_req, mem_we, mem_addr_sel, ir_load, imm_load, op1_load,
                   op2_load, alu_op, reg_load, pc_inc, pc_load, halted, bus_err,
                   illegal, state_dbg};
            compared++;
            if (got !== x.v) begin
                mismatched++;
                $display("FAIL vec%0d outputs got %05h want %05h", x.id, got, x.v);
            end
        end
    end

    initial begin
        // Reset held, then released in IDLE
        cyc(0, 1, 4'h0, 0, 0, 20'h0);
        cyc(0, 1, 4'h0, 0, 1, 20'h0);
        cyc(1, 1, 4'h0, 0, 0, 20'h0);
        // ADD
        cyc(1, 1, 4'h0, 0, 0, REQ | 1);
        cyc(1, 1, 4'h2, 0, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 0, 0, OPS | 2);
        cyc(1, 1, 4'h0, 0, 0, alu(3'b010) | 4);
        cyc(1, 1, 4'h0, 0, 1, RL | 6);
        cyc(1, 1, 4'h0, 0, 0, REQ | 1);
        // MVI
        cyc(1, 1, 4'h1, 0, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 0, 0, OPS | 2);
        cyc(1, 1, 4'h0, 0, 0, REQ | SEL1 | 3);
        cyc(1, 1, 4'h0, 0, 1, REQ | SEL1 | IMV | PCI | 3);
        cyc(1, 1, 4'h0, 0, 0, RL | 6);
        // JZ taken, then not taken
        cyc(1, 1, 4'hB, 0, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 0, 0, OPS | 2);
        cyc(1, 1, 4'h0, 1, 0, PCL | 4);
        cyc(1, 1, 4'hB, 1, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 1, 0, OPS | 2);
        cyc(1, 1, 4'h0, 0, 0, 4);
        // ST with ack after five waiting cycles
        cyc(1, 1, 4'h9, 0, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 0, 0, OPS | 2);
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 4'h0, 0, 0, REQ | WE | SEL2 | 5);
        cyc(1, 1, 4'h0, 0, 1, REQ | WE | SEL2 | 5);
        // Undefined opcode 0xD
        cyc(1, 1, 4'hD, 0, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 0, 0, OPS | 2);
        cyc(1, 1, 4'h0, 0, 0, ILL | 4);
        // LD aborted by en dropping mid-MEM
        cyc(1, 1, 4'h8, 0, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 0, 0, OPS | 2);
        cyc(1, 1, 4'h0, 0, 0, REQ | SEL2 | 5);
        cyc(1, 0, 4'h0, 0, 1, REQ | SEL2 | 5);
        cyc(1, 0, 4'h0, 0, 0, 20'h0);
        cyc(1, 1, 4'h0, 0, 0, 20'h0);
        // Ack on the last allowed cycle beats the timeout (MOV)
        for (int i = 0; i < 15; i++)
            cyc(1, 1, 4'h0, 0, 0, REQ | 1);
        cyc(1, 1, 4'h0, 0, 1, REQ | IR | PCI | 1);
        cyc(1, 1, 4'h0, 0, 0, OPS | 2);
        cyc(1, 1, 4'h0, 0, 0, alu(3'b000) | 4);
        cyc(1, 1, 4'h0, 0, 0, RL | 6);
        // No ack: timeout after 16 request cycles
        for (int i = 0; i < 16; i++)
            cyc(1, 1, 4'h0, 0, 0, REQ | 1);
        cyc(1, 1, 4'h0, 0, 0, HLT | BERR | 7);
        cyc(1, 0, 4'h0, 0, 0, HLT | BERR | 7);
        cyc(1, 1, 4'h0, 0, 1, HLT | BERR | 7);
        cyc(1, 0, 4'h0, 0, 0, HLT | BERR | 7);
        // Reset pulse clears everything
        cyc(0, 1, 4'h0, 0, 0, 20'h0);
        cyc(1, 0, 4'h0, 0, 0, 20'h0);
        cyc(1, 1, 4'h0, 0, 0, 20'h0);
        cyc(1, 1, 4'h0, 0, 0, REQ | 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        #5;
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
